// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings for the fetch-side program counter sequencer
// Contents: PC_OP_* branch op codes, COND_* jump conditions, FLAG_* bit indices
// into the {Z,N,C,V} status register, sequencer state type, condition evaluator.
package pc_sequencer_pkg;

    localparam logic [2:0] PC_OP_NEXT = 3'd0;
    localparam logic [2:0] PC_OP_JUMP = 3'd1;
    localparam logic [2:0] PC_OP_CALL = 3'd2;
    localparam logic [2:0] PC_OP_RET  = 3'd3;
    localparam logic [2:0] PC_OP_HALT = 3'd4;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_EQ     = 3'd1;
    localparam logic [2:0] COND_NE     = 3'd2;
    localparam logic [2:0] COND_GT     = 3'd3;
    localparam logic [2:0] COND_GE     = 3'd4;
    localparam logic [2:0] COND_LT     = 3'd5;
    localparam logic [2:0] COND_LE     = 3'd6;
    localparam logic [2:0] COND_CS     = 3'd7;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    // Jump condition truth against the registered status flags.
    function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
        logic r;
        case (c)
            COND_ALWAYS: r = 1'b1;
            COND_EQ:     r = f[FLAG_Z];
            COND_NE:     r = !f[FLAG_Z];
            COND_GT:     r = !f[FLAG_Z] && !f[FLAG_N];
            COND_GE:     r = !f[FLAG_N];
            COND_LT:     r = f[FLAG_N];
            COND_LE:     r = f[FLAG_N] || f[FLAG_Z];
            default:     r = f[FLAG_C];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// rtl/pc_sequencer_ret_stack.sv - DEPTH x AW return-address LIFO
// Ports: clk, reset (sync, active-high), push/push_data, pop,
// top (entry at count-1), full, empty, count (occupancy 0..DEPTH).
module ret_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [AW-1:0]            push_data,
    input  logic                     pop,
    output logic [AW-1:0]            top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW:0]   count_q;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] top_idx;

    // The low bits of the occupancy address the next free slot; when full
    // they wrap to 0, so count-1 in PW bits still names the topmost entry.
    assign wr_idx  = count_q[PW-1:0];
    assign top_idx = wr_idx - 1'b1;

    assign top   = mem[top_idx];
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + 1'b1;
        end else if (pop && !empty) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with conditional jumps, call/return stack and halt
// Ports: clk, reset (sync, active-high); pc_op, cond, target, alu_z/n/c/v, flag_we,
// stall in; pc, flags {Z,N,C,V}, taken (comb), sp, halted, stack_err (sticky) out.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               pc_op,
    input  logic [2:0]               cond,
    input  logic [AW-1:0]            target,
    input  logic                     alu_z,
    input  logic                     alu_n,
    input  logic                     alu_c,
    input  logic                     alu_v,
    input  logic                     flag_we,
    input  logic                     stall,
    output logic [AW-1:0]            pc,
    output logic [3:0]               flags,
    output logic                     taken,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     halted,
    output logic                     stack_err
);
    seq_state_t    state;
    logic [AW-1:0] pc_q;
    logic [3:0]    flags_q;
    logic          stack_err_q;

    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;
    logic          active;
    logic          cond_ok;
    logic          do_jump;
    logic          do_push;
    logic          do_pop;
    logic          fault;

    assign pc_plus1 = pc_q + 1'b1;

    always_comb begin
        active  = (state == ST_RUN) && !stall;
        cond_ok = cond_true(cond, flags_q);
        do_jump = active && (pc_op == PC_OP_JUMP) && cond_ok;
        do_push = active && (pc_op == PC_OP_CALL) && !stk_full;
        do_pop  = active && (pc_op == PC_OP_RET) && !stk_empty;
        fault   = active && (((pc_op == PC_OP_CALL) && stk_full) ||
                             ((pc_op == PC_OP_RET) && stk_empty));
        taken   = do_jump || do_push || do_pop;
    end

    ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (do_push),
        .push_data (pc_plus1),
        .pop       (do_pop),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .count     (sp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            pc_q        <= '0;
            flags_q     <= '0;
            stack_err_q <= 1'b0;
        end else if (active) begin
            if (flag_we) begin
                flags_q <= {alu_z, alu_n, alu_c, alu_v};
            end
            case (pc_op)
                PC_OP_JUMP: pc_q <= cond_ok ? target : pc_plus1;
                PC_OP_CALL: if (!stk_full)  pc_q <= target;
                PC_OP_RET:  if (!stk_empty) pc_q <= stk_top;
                PC_OP_HALT: pc_q <= pc_q;
                default:    pc_q <= pc_plus1;
            endcase
            // A stack fault freezes the sequencer exactly like an explicit HALT.
            if ((pc_op == PC_OP_HALT) || fault) begin
                state <= ST_HALT;
            end
            if (fault) begin
                stack_err_q <= 1'b1;
            end
        end
    end

    assign pc        = pc_q;
    assign flags     = flags_q;
    assign halted    = (state == ST_HALT);
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_CALL = 3'd2,
                           OP_RET = 3'd3, OP_HALT = 3'd4;
    localparam logic [2:0] C_AL = 3'd0, C_EQ = 3'd1, C_NE = 3'd2, C_LT = 3'd5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    pc_op = '0;
    logic [2:0]    cond = '0;
    logic [AW-1:0] target = '0;
    logic          alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic          flag_we = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] pc;
    logic [3:0]    flags;
    logic          taken;
    logic [2:0]    sp;
    logic          halted;
    logic          stack_err;

    pc_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_op(pc_op), .cond(cond), .target(target),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .flag_we(flag_we), .stall(stall), .pc(pc), .flags(flags), .taken(taken),
        .sp(sp), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers and a queue for the return stack.
    int m_pc;
    int m_z, m_n, m_c, m_v;
    int m_stk[$];
    int m_halt;
    int m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_cond(input int c);
        case (c)
            0: return 1;
            1: return m_z;
            2: return !m_z;
            3: return !m_z && !m_n;
            4: return !m_n;
            5: return m_n;
            6: return m_n || m_z;
            default: return m_c;
        endcase
    endfunction

    task automatic cyc(input logic [2:0] op, input logic [2:0] c, input logic [7:0] t,
                       input logic [3:0] f, input logic we, input logic st, input logic rs);
        int exp_taken;
        int ok;
        @(negedge clk);
        pc_op = op; cond = c; target = t; flag_we = we; stall = st; reset = rs;
        {alu_z, alu_n, alu_c, alu_v} = f;
        exp_taken = 0;
        if (!m_halt && !st) begin
            if (op == OP_JUMP) exp_taken = m_cond(c);
            if (op == OP_CALL) exp_taken = (m_stk.size() < DEPTH);
            if (op == OP_RET)  exp_taken = (m_stk.size() > 0);
        end
        #1;
        if (!rs) check("taken", 32'(taken), 32'(exp_taken));
        @(posedge clk);
        #1;
        if (rs) begin
            m_pc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
            m_stk.delete(); m_halt = 0; m_err = 0;
        end else if (!m_halt && !st) begin
            ok = m_cond(c);
            if (we) begin
                m_z = f[3]; m_n = f[2]; m_c = f[1]; m_v = f[0];
            end
            case (op)
                OP_JUMP: m_pc = ok ? int'(t) : (m_pc + 1) % 256;
                OP_CALL: if (m_stk.size() < DEPTH) begin
                             m_stk.push_back((m_pc + 1) % 256);
                             m_pc = t;
                         end else begin
                             m_err = 1; m_halt = 1;
                         end
                OP_RET:  if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                         else begin m_err = 1; m_halt = 1; end
                OP_HALT: m_halt = 1;
                default: m_pc = (m_pc + 1) % 256;
            endcase
        end
        check("pc", 32'(pc), 32'(m_pc));
        check("flags", 32'(flags), 32'({m_z[0], m_n[0], m_c[0], m_v[0]}));
        check("sp", 32'(sp), 32'(m_stk.size()));
        check("halted", 32'(halted), 32'(m_halt));
        check("stack_err", 32'(stack_err), 32'(m_err));
        reset = 1'b0;
    endtask

    task automatic op(input logic [2:0] o, input logic [2:0] c, input logic [7:0] t);
        cyc(o, c, t, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(OP_NEXT, C_AL, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        m_pc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_halt = 0; m_err = 0;

        // Reset and sequential fetch, including the 0xFF -> 0x00 wrap.
        do_reset();
        check("rst_pc", 32'(pc), 32'h0);
        for (int i = 0; i < 5; i++) op(OP_NEXT, C_AL, 8'h00);
        check("next5_pc", 32'(pc), 32'h5);
        op(OP_JUMP, C_AL, 8'hFE);
        op(OP_NEXT, C_AL, 8'h00);
        check("wrap_ff", 32'(pc), 32'hFF);
        op(OP_NEXT, C_AL, 8'h00);
        check("wrap_00", 32'(pc), 32'h00);

        // Flag write in the same cycle as JEQ uses old Z; next JEQ is taken.
        cyc(OP_JUMP, C_EQ, 8'h40, 4'b1000, 1'b1, 1'b0, 1'b0);
        check("jeq_old_flags", 32'(pc), 32'h01);
        op(OP_JUMP, C_EQ, 8'h40);
        check("jeq_taken", 32'(pc), 32'h40);
        op(OP_JUMP, C_NE, 8'h80);
        check("jne_not_taken", 32'(pc), 32'h41);
        op(OP_JUMP, C_LT, 8'h80);
        cyc(OP_NEXT, C_AL, 8'h00, 4'b0100, 1'b1, 1'b0, 1'b0);
        op(OP_JUMP, C_LT, 8'h90);
        check("jlt_taken", 32'(pc), 32'h90);

        // Nested call / return.
        do_reset();
        for (int i = 0; i < 5; i++) op(OP_NEXT, C_AL, 8'h00);
        op(OP_CALL, C_AL, 8'h20);
        op(OP_CALL, C_AL, 8'h30);
        op(OP_RET, C_AL, 8'h00);
        check("ret1_pc", 32'(pc), 32'h21);
        op(OP_RET, C_AL, 8'h00);
        check("ret2_pc", 32'(pc), 32'h06);
        check("ret2_sp", 32'(sp), 32'h0);

        // Overflow: fifth CALL halts with the stack error set; HALT ignores inputs.
        do_reset();
        for (int i = 0; i < 4; i++) op(OP_CALL, C_AL, 8'(8'h10 + i));
        op(OP_CALL, C_AL, 8'h70);
        check("ovf_halted", 32'(halted), 32'h1);
        check("ovf_err", 32'(stack_err), 32'h1);
        check("ovf_sp", 32'(sp), 32'h4);
        cyc(OP_JUMP, C_AL, 8'h55, 4'hF, 1'b1, 1'b0, 1'b0);
        cyc(OP_RET, C_AL, 8'h00, 4'hA, 1'b1, 1'b0, 1'b0);
        do_reset();
        check("ovf_rst_err", 32'(stack_err), 32'h0);

        // Underflow, then explicit HALT without error.
        op(OP_JUMP, C_AL, 8'h10);
        op(OP_RET, C_AL, 8'h00);
        check("unf_pc", 32'(pc), 32'h10);
        check("unf_err", 32'(stack_err), 32'h1);
        do_reset();
        op(OP_HALT, C_AL, 8'h00);
        check("halt_err", 32'(stack_err), 32'h0);
        op(OP_NEXT, C_AL, 8'h00);

        // Stall freezes a pending jump and flag write; reset wins over stall.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(OP_JUMP, C_AL, 8'h80, 4'hF, 1'b1, 1'b1, 1'b0);
        op(OP_JUMP, C_AL, 8'h80);
        check("stall_release", 32'(pc), 32'h80);
        cyc(OP_JUMP, C_AL, 8'h33, 4'h0, 1'b0, 1'b1, 1'b1);
        check("stall_rst_pc", 32'(pc), 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] ro;
            int pick;
            pick = $urandom_range(0, 99);
            if (pick < 35)      ro = OP_NEXT;
            else if (pick < 60) ro = OP_JUMP;
            else if (pick < 78) ro = OP_CALL;
            else if (pick < 96) ro = OP_RET;
            else if (pick < 98) ro = OP_HALT;
            else                ro = 3'($urandom_range(5, 7));
            cyc(ro, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0), (m_halt != 0) && ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
